seq_mult: RTL and testbench
===========================

Name: seq_mult

Overview:
- Parametrised sequential shift-add multiplier for the Multiplier project.
- Uses one WIDTH-bit carry-lookahead adder iteratively: one partial product per clock.
- Start/busy/done handshake; the product is held stable until the next accepted start.
- Generalises the 16-bit combinational CLA datapath to any width, adding multi-cycle control and an optional signed mode.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits; legal range 4..64.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rst  input  1  synchronous active-high reset.
- start  input  1  request; sampled only when state is IDLE or DONE.
- in1  input  WIDTH  multiplicand; captured on an accepted start.
- in2  input  WIDTH  multiplier; captured on an accepted start.
- busy  output  1  high while state is RUN.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  result register; held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- Reset values: state=IDLE, busy=0, done=0, product=0, count=0, acc=0, mq=0, mcand=0.
- Reset has priority over everything and aborts any multiplication in progress.
- States:
  - IDLE: start=1 -> load mcand=in1, mq=in2, acc=0, count=0; go to RUN.
  - RUN: busy=1. Each cycle compute {c,s}=acc+(mq[0]?mcand:0) through the CLA with cin=0. Then {acc,mq} <= {c,s,mq}>>1 (a 2*WIDTH+1-bit right shift), and count++.
  - RUN exit: on the cycle with count==WIDTH-1, product <= shifted {acc,mq}, done<=1, go to DONE.
  - DONE: done=1 for exactly this cycle. start=1 -> load as in IDLE and go to RUN (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: start accepted at edge k -> busy high from k+1 through k+WIDTH -> done high and product valid from edge k+WIDTH for one cycle.
- Ignored start: start while in RUN is ignored and has no side effects.
- Operand changes: changes on in1/in2 after acceptance do not affect the result.
- Product update: product changes only at the completion edge; its value is unchanged while busy.
- Width rules:
  - acc is WIDTH bits; the adder carry-out becomes the shift-in MSB, so nothing is lost.
  - Unsigned result is exact for all inputs; maximum is (2^WIDTH-1)^2.
- Boundaries:
  - in2=0 still takes the full WIDTH cycles (fixed latency).
  - in1=0 yields 0.
  - All-ones operands must exercise the carry into the MSB.

Optional Feature:
- Macro: SEQ_MULT_SIGNED_EN.
- Defined:
  - Adds input port sgn (1 bit), sampled with start.
  - When sgn=1, operands are two's complement:
    - Record neg = in1[MSB]^in2[MSB].
    - Load magnitudes (conditional negate); the most negative value maps to 2^(WIDTH-1), which fits unsigned.
    - At completion, product = neg ? -result : result (2*WIDTH-bit two's complement negate, same edge).
  - sgn=0 behaves exactly as unsigned.
- Not defined:
  - No sgn port; unsigned only.
  - Timing is identical in both builds.

Decomposition:
- Package mult_pkg holds:
  - the state typedef {IDLE, RUN, DONE} in a 2-bit encoding;
  - the default width constant MULT_WIDTH_DEF=16.
- One sub-module, cla_adder_p:
  - parametrised WIDTH-bit carry-lookahead adder (in1, in2, cin, sum, cout);
  - 4-bit lookahead groups with a ripple between groups;
  - instantiated once in seq_mult.

Test Plan:
- rst, then start with in1=10, in2=20 -> busy for 16 cycles, done pulse at edge k+16, product=200; product stays 200 and done=0 afterwards.
- in1=16'hFFFF, in2=16'hFFFF -> product=32'hFFFE0001; then in1=16'h7FFF, in2=16'hFFFF -> product=32'h7FFE8001.
- start held high continuously, with operand pairs (3,5) then (16'hBFFF,2) -> done every 17 cycles; products 15 then 32'h00017FFE; mid-RUN operand changes have no effect.
- Assert rst for one cycle at RUN cycle 7 -> next cycle state IDLE, busy=0, done=0, product=0; a subsequent start works normally.
- in2=0, in1=16'h1234 -> latency still 16 cycles, product=0.
- SEQ_MULT_SIGNED_EN: sgn=1, in1=16'hFFFF, in2=2 -> 32'hFFFFFFFE; in1=in2=16'h8000 -> 32'h40000000; sgn=0 same operands -> 32'h40000000.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the sequential multiplier.
// Exports: state_t (IDLE/RUN/DONE) and MULT_WIDTH_DEF.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int MULT_WIDTH_DEF = 16;

endpackage

// File: rtl/cla_adder_p.sv
// Parametrised carry-lookahead adder.
// Ports: in1, in2 (WIDTH), cin -> sum (WIDTH), cout.
// Carries are fully looked ahead inside 4-bit groups;
// group carries ripple from one group to the next.
module cla_adder_p #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = (WIDTH + 3) / 4;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;

  assign g = in1 & in2;
  assign p = in1 ^ in2;

  for (genvar j = 0; j < NG; j++) begin : g_grp
    localparam int B  = 4 * j;
    localparam int GW = (WIDTH - B >= 4) ? 4 : WIDTH - B;

    logic          ci;
    logic          co;
    logic [GW-1:0] gg;
    logic [GW-1:0] pp;
    logic [GW:0]   cc;

    if (j == 0) begin : g_first
      assign ci = cin;
    end else begin : g_next
      assign ci = g_grp[j-1].co;
    end

    assign gg    = g[B+GW-1:B];
    assign pp    = p[B+GW-1:B];
    assign cc[0] = ci;

    // Every carry depends only on group g/p and ci,
    // never on a lower carry of the same group.
    for (genvar m = 1; m <= GW; m++) begin : g_m
      logic [m:0] t;
      for (genvar k = 0; k < m; k++) begin : g_k
        if (k == m - 1) begin : g_top
          assign t[k] = gg[k];
        end else begin : g_prop
          assign t[k] = gg[k] & (&pp[m-1:k+1]);
        end
      end
      assign t[m]  = (&pp[m-1:0]) & ci;
      assign cc[m] = |t;
    end

    assign sum[B+GW-1:B] = pp ^ cc[GW-1:0];
    assign co            = cc[GW];
  end

  assign cout = g_grp[NG-1].co;

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-add multiplier, one partial product per clock.
// Ports: clk, rst (sync, active-high), start, in1, in2 -> busy, done,
// product (2*WIDTH, held until next accepted start).
// Optional macro SEQ_MULT_SIGNED_EN adds input sgn for two's complement.
module seq_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
`ifdef SEQ_MULT_SIGNED_EN
  input  logic               sgn,
`endif
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mq;
  logic [WIDTH-1:0]   mcand;
  logic [CNT_W-1:0]   count;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   mq_nx;
  logic [2*WIDTH-1:0] result;
  logic [2*WIDTH-1:0] prod_nx;
  logic [WIDTH-1:0]   ld_mcand;
  logic [WIDTH-1:0]   ld_mq;

  assign addend = mq[0] ? mcand : '0;

  cla_adder_p #(
    .WIDTH(WIDTH)
  ) u_cla (
    .in1  (acc),
    .in2  (addend),
    .cin  (1'b0),
    .sum  (sum),
    .cout (cout)
  );

  // {cout,sum,mq} >> 1: carry-out becomes the new acc MSB.
  assign acc_nx = {cout, sum[WIDTH-1:1]};
  assign mq_nx  = {sum[0], mq[WIDTH-1:1]};
  assign result = {acc_nx, mq_nx};

`ifdef SEQ_MULT_SIGNED_EN
  logic neg;
  logic ld_neg;

  // Magnitudes: the most negative value maps to 2^(WIDTH-1).
  assign ld_mcand = (sgn & in1[WIDTH-1]) ? -in1 : in1;
  assign ld_mq    = (sgn & in2[WIDTH-1]) ? -in2 : in2;
  assign ld_neg   = sgn & (in1[WIDTH-1] ^ in2[WIDTH-1]);
  assign prod_nx  = neg ? -result : result;
`else
  assign ld_mcand = in1;
  assign ld_mq    = in2;
  assign prod_nx  = result;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      count   <= '0;
      acc     <= '0;
      mq      <= '0;
      mcand   <= '0;
`ifdef SEQ_MULT_SIGNED_EN
      neg     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            mcand <= ld_mcand;
            mq    <= ld_mq;
            acc   <= '0;
            count <= '0;
`ifdef SEQ_MULT_SIGNED_EN
            neg   <= ld_neg;
`endif
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc   <= acc_nx;
          mq    <= mq_nx;
          count <= count + CNT_W'(1);
          if (count == LAST) begin
            product <= prod_nx;
            done    <= 1'b1;
            busy    <= 1'b0;
            state   <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (WIDTH=16).
// Scoreboard queue holds expected products in issue order.
module tb_seq_mult;

  localparam int W = 16;
  localparam int LAT = W + 1;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   in1;
  logic [W-1:0]   in2;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef SEQ_MULT_SIGNED_EN
  logic           sgn;
`endif

  int errors = 0;
  int checks = 0;
  logic [2*W-1:0] exp_q[$];

  always #5 clk = ~clk;

  seq_mult #(
    .WIDTH(W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef SEQ_MULT_SIGNED_EN
    .sgn     (sgn),
`endif
    .in1     (in1),
    .in2     (in2),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] m;
    m = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    in1 = a;
    in2 = b;
    start = 1'b1;
`ifdef SEQ_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    exp_q.push_back(m);
  endtask

  task automatic pop_exp(output logic [2*W-1:0] e);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else e = 'x;
  endtask

  // Called at a negedge numbered n0 after the accepting edge.
  task automatic wait_done(input int n0, output int n, output int bc,
                           output bit chg);
    logic [2*W-1:0] p0;
    p0 = product;
    n = n0;
    bc = 0;
    chg = 1'b0;
    while (!done && n < 80) begin
      if (busy) bc++;
      if (product !== p0) chg = 1'b1;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    start = 1'b0;
    in1 = '0;
    in2 = '0;
`ifdef SEQ_MULT_SIGNED_EN
    sgn = 1'b0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done got %b want 0", done);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL reset_product got %h want 0", product);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'd10, 16'd20);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL basic_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (bc !== W) begin
      errors++;
      $display("FAIL basic_busy_cycles got %0d want %0d", bc, W);
    end
    checks++;
    if (chg !== 1'b0) begin
      errors++;
      $display("FAIL basic_hold_while_busy got %b want 0", chg);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL basic_product got %h want %h", product, e);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_pulse got %b want 0", done);
    end
    checks++;
    if (product !== 32'd200) begin
      errors++;
      $display("FAIL basic_product_held got %h want %h", product, 32'd200);
    end
  endtask

  task automatic test_ignored_start;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'h0101, 16'h0003);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    in1 = 16'hFFFF;
    in2 = 16'hFFFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(7, n, bc, chg);
    pop_exp(e);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL ignored_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL ignored_product got %h want %h", product, e);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL ignored_no_rerun got %b want 0", busy);
    end
  endtask

  task automatic test_all_ones;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'hFFFF, 16'hFFFF);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== 32'hFFFE0001 || product !== e) begin
      errors++;
      $display("FAIL ones_ffff got %h want %h", product, e);
    end
    @(negedge clk);
    issue(16'h7FFF, 16'hFFFF);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== 32'h7FFE8001 || product !== e) begin
      errors++;
      $display("FAIL ones_7fff got %h want %h", product, e);
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL ones_latency got %0d want %0d", n, LAT);
    end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'd3, 16'd5);
    @(negedge clk);
    issue(16'hBFFF, 16'd2);
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL b2b_first got %h want %h", product, e);
    end
    @(negedge clk);
    start = 1'b0;
    in1 = 16'hAAAA;
    in2 = 16'h5555;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL b2b_period got %0d want %0d", n, LAT);
    end
    checks++;
    if (product !== 32'h00017FFE || product !== e) begin
      errors++;
      $display("FAIL b2b_second got %h want %h", product, e);
    end
  endtask

  task automatic test_reset_abort;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'd9, 16'd9);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got %b want 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL abort_done got %b want 0", done);
    end
    checks++;
    if (product !== '0) begin
      errors++;
      $display("FAIL abort_product got %h want 0", product);
    end
    issue(16'd6, 16'd7);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL abort_next_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL abort_next_product got %h want %h", product, e);
    end
  endtask

  task automatic test_zero;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue(16'h1234, 16'h0000);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL zero_mq_latency got %0d want %0d", n, LAT);
    end
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL zero_mq_product got %h want %h", product, e);
    end
    @(negedge clk);
    issue(16'h0000, 16'hFFFF);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== e) begin
      errors++;
      $display("FAIL zero_mcand_product got %h want %h", product, e);
    end
  endtask

`ifdef SEQ_MULT_SIGNED_EN
  task automatic issue_s(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] m;
    m = {{W{a[W-1]}}, a} * {{W{b[W-1]}}, b};
    in1 = a;
    in2 = b;
    start = 1'b1;
    sgn = 1'b1;
    exp_q.push_back(m);
  endtask

  task automatic test_signed;
    int n, bc;
    bit chg;
    logic [2*W-1:0] e;
    @(negedge clk);
    issue_s(16'hFFFF, 16'd2);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== 32'hFFFFFFFE || product !== e) begin
      errors++;
      $display("FAIL signed_m1x2 got %h want %h", product, e);
    end
    checks++;
    if (n !== LAT) begin
      errors++;
      $display("FAIL signed_latency got %0d want %0d", n, LAT);
    end
    @(negedge clk);
    issue_s(16'h8000, 16'h8000);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== 32'h40000000 || product !== e) begin
      errors++;
      $display("FAIL signed_min_sq got %h want %h", product, e);
    end
    @(negedge clk);
    issue(16'h8000, 16'h8000);
    @(negedge clk);
    start = 1'b0;
    wait_done(1, n, bc, chg);
    pop_exp(e);
    checks++;
    if (product !== 32'h40000000 || product !== e) begin
      errors++;
      $display("FAIL unsigned_8000_sq got %h want %h", product, e);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_ignored_start();
    test_all_ones();
    test_back_to_back();
    test_reset_abort();
    test_zero();
`ifdef SEQ_MULT_SIGNED_EN
    test_signed();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
